// File: rtl/wb_queue.sv
// Writeback queue: a small circular FIFO of pending register-file writes.
// Entries drain to the register-file write port whenever HOLD is low.
// Pending entries can be looked up by two decode-stage forwarding ports,
// which return the youngest matching value.
//
// Handshake: an entry transfers on a rising CLK edge where IN_VALID and
// IN_READY are both high. IN_READY depends only on occupancy, so the
// producer never has to wait on the same-cycle drain decision. The drain
// side has no ready: WE3 high at a rising edge means the register file
// commits A3/WD3 on that edge and the head entry pops.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  input  logic [4:0]               IN_A3,
  input  logic [31:0]              IN_WD,
  output logic                     IN_READY,
  input  logic                     HOLD,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  input  logic [4:0]               Q1,
  input  logic [4:0]               Q2,
  output logic                     HIT1,
  output logic                     HIT2,
  output logic [31:0]              FWD1,
  output logic [31:0]              FWD2,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]  addr_mem_q [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count_q != '0);
  assign IN_READY  = (count_q < CW'(DEPTH));
  assign WE3       = not_empty & ~HOLD;
  assign A3        = not_empty ? addr_mem_q[head_q] : 5'd0;
  assign WD3       = not_empty ? data_mem_q[head_q] : 32'd0;
  assign COUNT     = count_q;

  // Writes to register zero complete the handshake but are never stored.
  assign push = IN_VALID & IN_READY & (IN_A3 != 5'd0);
  assign pop  = WE3;

  // Next-state pointers and occupancy.
  always_comb begin
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Pointer and occupancy registers; reset drops every pending entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem_q[tail_q] <= IN_A3;
      data_mem_q[tail_q] <= IN_WD;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [AW-1:0] idx;
    HIT1 = 1'b0;
    HIT2 = 1'b0;
    FWD1 = 32'd0;
    FWD2 = 32'd0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + i[AW-1:0];
      if (i < int'(count_q)) begin
        if ((Q1 != 5'd0) && (addr_mem_q[idx] == Q1)) begin
          HIT1 = 1'b1;
          FWD1 = data_mem_q[idx];
        end
        if ((Q2 != 5'd0) && (addr_mem_q[idx] == Q2)) begin
          HIT2 = 1'b1;
          FWD2 = data_mem_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [4:0]  IN_A3 = 5'd0;
  logic [31:0] IN_WD = 32'd0;
  logic        IN_READY;
  logic        HOLD = 1'b0;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  Q1 = 5'd0;
  logic [4:0]  Q2 = 5'd0;
  logic        HIT1, HIT2;
  logic [31:0] FWD1, FWD2;
  logic [2:0]  COUNT;

  int tests = 0;
  int fails = 0;

  // Reference model: pending entries {addr, data}, oldest at index 0.
  logic [36:0] exp_q[$];
  // Writes the DUT actually issued, in commit order.
  logic [36:0] dut_log[$];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_A3(IN_A3), .IN_WD(IN_WD),
    .IN_READY(IN_READY), .HOLD(HOLD), .WE3(WE3), .A3(A3), .WD3(WD3),
    .Q1(Q1), .Q2(Q2), .HIT1(HIT1), .HIT2(HIT2), .FWD1(FWD1), .FWD2(FWD2),
    .COUNT(COUNT)
  );

  // Clock.
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, using the pre-edge occupancy.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      int  n;
      logic do_pop, do_acc;
      n = exp_q.size();
      do_pop = (n != 0) && !HOLD;
      do_acc = IN_VALID && (n < DEPTH) && (IN_A3 != 5'd0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc) exp_q.push_back({IN_A3, IN_WD});
    end
  end

  // Compare process: every output against the model, once per cycle.
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_f1, m_f2;
  logic        m_h1, m_h2;
  int          m_n;
  always @(negedge CLK) begin
    m_n = exp_q.size();
    m_a3 = (m_n != 0) ? exp_q[0][36:32] : 5'd0;
    m_wd = (m_n != 0) ? exp_q[0][31:0] : 32'd0;
    m_h1 = 1'b0; m_h2 = 1'b0; m_f1 = 32'd0; m_f2 = 32'd0;
    for (int i = 0; i < m_n; i++) begin
      if (Q1 != 5'd0 && exp_q[i][36:32] == Q1) begin m_h1 = 1'b1; m_f1 = exp_q[i][31:0]; end
      if (Q2 != 5'd0 && exp_q[i][36:32] == Q2) begin m_h2 = 1'b1; m_f2 = exp_q[i][31:0]; end
    end
    chk("m_ready", 32'(IN_READY), 32'(m_n < DEPTH));
    chk("m_we3",   32'(WE3),      32'((m_n != 0) && !HOLD));
    chk("m_a3",    32'(A3),       32'(m_a3));
    chk("m_wd3",   WD3,           m_wd);
    chk("m_count", 32'(COUNT),    32'(m_n));
    chk("m_hit1",  32'(HIT1),     32'(m_h1));
    chk("m_fwd1",  FWD1,          m_f1);
    chk("m_hit2",  32'(HIT2),     32'(m_h2));
    chk("m_fwd2",  FWD2,          m_f2);
    if (WE3 === 1'b1) dut_log.push_back({A3, WD3});
  end

  // Driver helpers: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic look();
    @(negedge CLK); #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] a, input logic [31:0] d);
    IN_VALID = v; IN_A3 = a; IN_WD = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int nx;
    logic acc;

    // Reset state while RST is high.
    RST = 1'b1;
    cyc(); look();
    chk("rst_ready", 32'(IN_READY), 32'd1);
    chk("rst_we3",   32'(WE3),      32'd0);
    chk("rst_count", 32'(COUNT),    32'd0);
    chk("rst_wd3",   WD3,           32'd0);
    cyc();
    RST = 1'b0;

    // Single write: commit exactly one cycle after acceptance.
    offer(1'b1, 5'd5, 32'hDEAD_BEEF);
    look();
    chk("sw_we3_pre", 32'(WE3), 32'd0);
    cyc();
    offer(1'b0, 5'd0, 32'd0);
    look();
    chk("sw_we3",   32'(WE3),   32'd1);
    chk("sw_a3",    32'(A3),    32'd5);
    chk("sw_wd3",   WD3,        32'hDEAD_BEEF);
    chk("sw_count", 32'(COUNT), 32'd1);
    cyc(); look();
    chk("sw_we3_post", 32'(WE3),   32'd0);
    chk("sw_count0",   32'(COUNT), 32'd0);
    cyc();

    // Fill under HOLD, backpressure, then in-order drain.
    dut_log.delete();
    HOLD = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 5'(i), 32'h100 + 32'(i));
      cyc();
    end
    offer(1'b1, 5'd5, 32'h105);
    look();
    chk("fill_ready", 32'(IN_READY), 32'd0);
    chk("fill_count", 32'(COUNT),    32'd4);
    chk("fill_we3",   32'(WE3),      32'd0);
    cyc();
    HOLD = 1'b0;
    nx = 0;
    for (int c = 0; c < 10 && nx == 0; c++) begin
      look(); acc = IN_READY; cyc();
      if (acc) nx = 1;
    end
    chk("fill_r5_acc", 32'(nx), 32'd1);
    offer(1'b0, 5'd0, 32'd0);
    idle(8);
    chk("fill_log_n", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
      chk("fill_log", 32'(dut_log[i]), 32'(((i + 1) << 32) | (32'h101 + i)));

    // Register zero: handshake completes, nothing stored or written.
    dut_log.delete();
    offer(1'b1, 5'd0, 32'h1234);
    Q1 = 5'd0;
    look();
    chk("r0_ready", 32'(IN_READY), 32'd1);
    cyc();
    offer(1'b0, 5'd0, 32'd0);
    look();
    chk("r0_count", 32'(COUNT), 32'd0);
    chk("r0_hit1",  32'(HIT1),  32'd0);
    idle(3);
    chk("r0_nolog", 32'(dut_log.size()), 32'd0);

    // Forwarding picks the youngest match; head stays visible until it pops.
    HOLD = 1'b1;
    offer(1'b1, 5'd7, 32'h11); cyc();
    offer(1'b1, 5'd7, 32'h22); cyc();
    offer(1'b0, 5'd0, 32'd0);
    Q1 = 5'd7; Q2 = 5'd8;
    look();
    chk("fw_hit1", 32'(HIT1), 32'd1);
    chk("fw_fwd1", FWD1,      32'h22);
    chk("fw_hit2", 32'(HIT2), 32'd0);
    chk("fw_fwd2", FWD2,      32'd0);
    cyc();
    HOLD = 1'b0;
    look();
    chk("fw_wd3_a",  WD3,  32'h11);
    chk("fw_fwd1_a", FWD1, 32'h22);
    cyc(); look();
    chk("fw_head_hit", 32'(HIT1), 32'd1);
    chk("fw_head_wd3", WD3,       32'h22);
    cyc(); look();
    chk("fw_drained_hit", 32'(HIT1), 32'd0);
    chk("fw_drained_fwd", FWD1,      32'd0);
    Q1 = 5'd0; Q2 = 5'd0;
    cyc();

    // Continuous traffic starting from full.
    dut_log.delete();
    HOLD = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      offer(1'b1, 5'(i), 32'hC000_0000 + 32'(i));
      cyc();
    end
    HOLD = 1'b0;
    nx = 14;
    for (int c = 0; c < 20 && nx < 18; c++) begin
      offer(1'b1, 5'(nx), 32'hC000_0000 + 32'(nx));
      look();
      if (c == 0) begin
        chk("pp_ready_full", 32'(IN_READY), 32'd0);
        chk("pp_count_full", 32'(COUNT),    32'd4);
      end else begin
        chk("pp_count", 32'(COUNT), 32'd3);
      end
      acc = IN_READY;
      cyc();
      if (acc) nx++;
    end
    chk("pp_all_acc", 32'(nx), 32'd18);
    offer(1'b0, 5'd0, 32'd0);
    idle(8);
    chk("pp_log_n", 32'(dut_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++)
      chk("pp_log", 32'(dut_log[i] >> 32), 32'(10 + i));

    // Reset pulse mid-drain drops pending entries immediately.
    HOLD = 1'b1;
    for (int i = 20; i <= 22; i++) begin
      offer(1'b1, 5'(i), 32'(i));
      cyc();
    end
    offer(1'b0, 5'd0, 32'd0);
    dut_log.delete();
    HOLD = 1'b0;
    #1;
    chk("mr_we3_pre", 32'(WE3), 32'd1);
    RST = 1'b1;
    #1;
    chk("mr_we3",   32'(WE3),      32'd0);
    chk("mr_count", 32'(COUNT),    32'd0);
    chk("mr_ready", 32'(IN_READY), 32'd1);
    chk("mr_a3",    32'(A3),       32'd0);
    RST = 1'b0;
    idle(4);
    chk("mr_nolog", 32'(dut_log.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
